// File: rtl/rr_mux_arbiter_4x1_pkg.sv
// Shared constants and state encoding for the round-robin 4:1 mux arbiter.
package rr_mux_arbiter_4x1_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

endpackage

// File: rtl/mux4.sv
// Structural single-bit 4:1 mux built from two levels of 2:1 selection.
module mux4
    import rr_mux_arbiter_4x1_pkg::*;
(
    input  logic [N_REQ-1:0] d,
    input  logic [SEL_W-1:0] s,
    output logic             y
);

    logic lo;
    logic hi;

    assign lo = s[0] ? d[1] : d[0];
    assign hi = s[0] ? d[3] : d[2];
    assign y  = s[1] ? hi : lo;

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick4
    import rr_mux_arbiter_4x1_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any
);

    logic             found;
    logic [SEL_W-1:0] cand;

    always_comb begin
        gnt_idx = ptr;
        found   = 1'b0;
        cand    = ptr;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = ptr + SEL_W'(k);
            if (!found && req[cand]) begin
                gnt_idx = cand;
                found   = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/rr_mux_arbiter_4x1.sv
// Round-robin burst arbiter driving a shared 4:1 data mux into one registered
// valid/ready output stage.
module rr_mux_arbiter_4x1
    import rr_mux_arbiter_4x1_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]       req_last,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic [SEL_W-1:0]       sel,
    output logic                   busy
);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_last_q;

    logic [SEL_W-1:0] gnt_idx;
    logic             any;
    logic             can_load;
    logic             load;
    logic [WIDTH-1:0] mux_data;
    logic             mux_last;

    rr_pick4 u_pick (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    // One structural mux per data bit, plus one for the last flag.
    for (genvar b = 0; b < int'(WIDTH); b++) begin : g_data_mux
        logic [N_REQ-1:0] lane_bits;
        for (genvar i = 0; i < int'(N_REQ); i++) begin : g_lane
            assign lane_bits[i] = req_data[i*int'(WIDTH) + b];
        end
        mux4 u_mux (
            .d (lane_bits),
            .s (sel_q),
            .y (mux_data[b])
        );
    end

    mux4 u_last_mux (
        .d (req_last),
        .s (sel_q),
        .y (mux_last)
    );

    assign can_load = !out_valid_q || out_ready;

    // Next-state, grant and handshake decode.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        req_ready = '0;
        load      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    sel_d   = gnt_idx;
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                req_ready[sel_q] = can_load;
                if (req_valid[sel_q] && can_load) begin
                    load = 1'b1;
                    if (mux_last) begin
                        state_d = ST_IDLE;
                        ptr_d   = sel_q + SEL_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
        end
    end

    // Output stage: a load replaces the held beat, otherwise a drain empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= mux_data;
            out_last_q  <= mux_last;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign sel       = sel_q;
    assign busy      = (state_q == ST_LOCK);

endmodule

// File: doc/rr_mux_arbiter_4x1.md
Name: rr_mux_arbiter_4x1

Overview:
Round-robin arbiter and sequencer for a shared 4:1 data mux. Four requesters send bursts through a valid/ready handshake. The arbiter grants one requester at a time, holds that grant until the burst's last beat is accepted, and drives the mux select. The selected beat is registered into a single output stage with a valid/ready handshake toward the downstream consumer.

Parameters:
WIDTH, 8, data width per requester and on the output.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  4  per-requester beat valid.
req_data  input  4*WIDTH  packed requester data; requester i occupies bits [i*WIDTH +: WIDTH].
req_last  input  4  per-requester last-beat-of-burst flag.
req_ready  output  4  per-requester beat accepted; at most one bit is high.
out_valid  output  1  output register holds a beat.
out_data  output  WIDTH  registered beat data.
out_last  output  1  registered last flag.
out_ready  input  1  downstream accepts the beat.
sel  output  2  current grant index and mux select.
busy  output  1  high while in LOCK.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ptr=0, sel=0, req_ready=0, out_valid=0, out_data=0, out_last=0, busy=0. Reset mid-burst abandons the burst. No partial beat survives.
- States: IDLE, LOCK.
- IDLE:
  - If req_valid!=0, the picker chooses the first i with req_valid[i]=1, scanning ptr, ptr+1, ... wrapping mod 4.
  - The next edge registers sel=i and moves to LOCK. busy=1 from that edge.
  - req_ready=0 in IDLE, so arbitration costs one cycle.
- LOCK:
  - can_load = !out_valid || out_ready.
  - req_ready[sel] = can_load. All other req_ready bits are 0.
  - A beat transfers when req_valid[sel] && req_ready[sel]. On that edge out_data=req_data[sel], out_last=req_last[sel], out_valid=1.
  - If the transferred beat has req_last=1: next state is IDLE, ptr=(sel+1) mod 4. sel holds its value.
- Output register:
  - If out_valid && out_ready and there is no load on the same edge, out_valid goes to 0 on that edge.
  - A simultaneous drain and load replaces the beat. Full throughput is 1 beat/cycle.
  - out_data and out_last hold their values while out_valid=1 && out_ready=0.
- Latency: a req_valid seen in IDLE at cycle t gives the grant edge at the end of t. The first beat is accepted during t+1, and out_valid=1 from t+2.
- Burst length is unbounded. Requesters that are not granted wait with no timeout.
- A requester that drops req_valid mid-burst keeps the lock. The arbiter never preempts.
- Changes on req_valid of a non-granted requester have no effect during LOCK.
- After the last beat of a burst is accepted, the arbiter returns to IDLE on the next edge. The next grant follows one cycle after that, so bursts are separated by at least one idle cycle on req_ready.
- ptr wraps from 3 to 0.
- sel changes only on a grant edge.

Decomposition:
- Shared constants header: N_REQ=4, state encodings ST_IDLE=1'b0 and ST_LOCK=1'b1.
- Sub-module rr_pick4 (combinational): inputs req[3:0] and ptr[1:0]; outputs gnt_idx[1:0] and any.
- Data selection: one 4:1 mux per data bit and one for last, both driven by sel. The team's structural 4:1 mux is instantiated here.

Test Plan:
- Reset then idle: all outputs 0 and busy=0. Assert rst_n=0 mid-burst with out_valid=1: out_valid=0 and sel=0 immediately, before the next clk edge.
- Single requester 2: 3-beat burst A1,A2,A3 (last on A3), out_ready=1. Expect sel=2 one cycle after the request, out_data A1,A2,A3 on consecutive cycles with out_last only on A3, then ptr=3.
- All four requesting 1-beat bursts continuously from reset: grant order 0,1,2,3,0. Each grant is exactly one cycle after the previous return to IDLE.
- Backpressure: burst from requester 1 with out_ready=0 for 3 cycles after the first beat. Expect out_data held, req_ready[1]=0 during the stall, and no beat lost or duplicated once out_ready=1.
- Lock hold: requester 0 is mid-burst and requester 3 asserts. Expect sel to stay 0 and req_ready[3]=0 until requester 0's last beat is accepted. Requester 3 is granted next.
- Wrap and priority: ptr=3 with req_valid=4'b1001 in IDLE. Expect sel=3 to be chosen. After that burst ends, ptr=0 and requester 0 wins.
